// File: rtl/spi_write_scheduler_if.sv
// Write-port bundle between pixel/fill producers, scheduler and driver.
// slave: scheduler view; master: producer/driver (bench) view.
interface spi_write_scheduler_if;
  logic        PIX_REQ;
  logic [16:0] PIX_ADDR;
  logic [15:0] PIX_DATA;
  logic        PIX_ACK;
  logic        FILL_START;
  logic [8:0]  FILL_X0;
  logic [7:0]  FILL_Y0;
  logic [8:0]  FILL_X1;
  logic [7:0]  FILL_Y1;
  logic [15:0] FILL_COLOR;
  logic        FILL_BUSY;
  logic        FILL_DONE;
  logic        ERR;
  logic        DRV_BUSY;
  logic [16:0] WA;
  logic [15:0] WD;
  logic        WE;

  modport slave (
    input  PIX_REQ, PIX_ADDR, PIX_DATA,
    input  FILL_START, FILL_X0, FILL_Y0,
    input  FILL_X1, FILL_Y1, FILL_COLOR,
    input  DRV_BUSY,
    output PIX_ACK, FILL_BUSY, FILL_DONE,
    output ERR, WA, WD, WE
  );

  modport master (
    output PIX_REQ, PIX_ADDR, PIX_DATA,
    output FILL_START, FILL_X0, FILL_Y0,
    output FILL_X1, FILL_Y1, FILL_COLOR,
    output DRV_BUSY,
    input  PIX_ACK, FILL_BUSY, FILL_DONE,
    input  ERR, WA, WD, WE
  );
endinterface

// File: rtl/spi_write_scheduler.sv
// Round-robin pixel/rect-fill scheduler for the SPI display write port.
// Ports: CLK_50MHz, RESET (sync, high), bus (pixel, fill, driver WA/WD/WE).
module spi_write_scheduler #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int WE_GAP = 4
) (
  input  logic CLK_50MHz,
  input  logic RESET,
  spi_write_scheduler_if.slave bus
);
  localparam int GW = $clog2(WE_GAP + 2);
  localparam logic [16:0] NPIX = 17'(WIDTH * HEIGHT);
  localparam logic [16:0] W17  = 17'(WIDTH);
  localparam logic [9:0]  XLIM = 10'(WIDTH);
  localparam logic [8:0]  YLIM = 9'(HEIGHT);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gap_q;
  logic          last_pix_q;
  logic          we_q, ack_q, done_q, err_q;
  logic [16:0]   wa_q;
  logic [15:0]   wd_q;
  logic          busy_q, fin_q;
  logic [8:0]    x0_q, x1_q, x_q;
  logic [7:0]    y1_q, y_q;
  logic [16:0]   faddr_q;
  logic [15:0]   color_q;

  logic pix_c, slot, pix_ok, start_ok;
  logic grant_pix, grant_fill, issue;

  always_comb begin
    pix_c      = bus.PIX_REQ && !ack_q;
    slot       = (state_q == IDLE) && !bus.DRV_BUSY;
    grant_pix  = slot && pix_c && (!busy_q || !last_pix_q);
    grant_fill = slot && busy_q && !grant_pix;
    pix_ok     = bus.PIX_ADDR < NPIX;
    issue      = grant_fill || (grant_pix && pix_ok);
    start_ok   = (bus.FILL_X0 <= bus.FILL_X1)
              && ({1'b0, bus.FILL_X1} < XLIM)
              && (bus.FILL_Y0 <= bus.FILL_Y1)
              && ({1'b0, bus.FILL_Y1} < YLIM);
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (issue) state_d = ISSUE;
      ISSUE:   state_d = GAP;
      GAP:     if (gap_q <= GW'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state_q    <= IDLE;
      gap_q      <= '0;
      last_pix_q <= 1'b0;
      we_q       <= 1'b0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      x0_q       <= '0;
      x1_q       <= '0;
      x_q        <= '0;
      y1_q       <= '0;
      y_q        <= '0;
      faddr_q    <= '0;
      color_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      if (state_q == ISSUE)
        gap_q <= GW'(WE_GAP);
      else if (gap_q != '0)
        gap_q <= gap_q - 1'b1;
      // Out-of-range pixels are acked and dropped in place.
      if (grant_pix) begin
        ack_q      <= 1'b1;
        last_pix_q <= 1'b1;
        if (pix_ok) begin
          we_q <= 1'b1;
          wa_q <= bus.PIX_ADDR;
          wd_q <= bus.PIX_DATA;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (grant_fill) begin
        we_q       <= 1'b1;
        wa_q       <= faddr_q;
        wd_q       <= color_q;
        last_pix_q <= 1'b0;
        if (x_q == x1_q) begin
          x_q     <= x0_q;
          y_q     <= y_q + 1'b1;
          faddr_q <= faddr_q + W17 - 17'(x1_q - x0_q);
          fin_q   <= (y_q == y1_q);
        end else begin
          x_q     <= x_q + 1'b1;
          faddr_q <= faddr_q + 1'b1;
        end
      end
      // Busy drops and done pulses the cycle after the final WE.
      if (state_q == ISSUE && fin_q) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        fin_q  <= 1'b0;
      end
      if (bus.FILL_START && !busy_q) begin
        if (start_ok) begin
          busy_q  <= 1'b1;
          x0_q    <= bus.FILL_X0;
          x1_q    <= bus.FILL_X1;
          x_q     <= bus.FILL_X0;
          y1_q    <= bus.FILL_Y1;
          y_q     <= bus.FILL_Y0;
          color_q <= bus.FILL_COLOR;
          faddr_q <= 17'(bus.FILL_Y0) * W17
                   + 17'(bus.FILL_X0);
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.WE        = we_q;
  assign bus.WA        = wa_q;
  assign bus.WD        = wd_q;
  assign bus.PIX_ACK   = ack_q;
  assign bus.FILL_BUSY = busy_q;
  assign bus.FILL_DONE = done_q;
  assign bus.ERR       = err_q;
endmodule

// File: tb/tb_spi_write_scheduler.sv
// Bench for spi_write_scheduler: directed cases plus random traffic
// checked every cycle against a queue-based reference model.
module tb_spi_write_scheduler;
  localparam int WIDTH  = 320;
  localparam int HEIGHT = 240;
  localparam int WE_GAP = 4;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic clk = 1'b0;
  logic RESET;
  spi_write_scheduler_if bus();

  spi_write_scheduler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .WE_GAP(WE_GAP)
  ) dut (
    .CLK_50MHz(clk),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // reference model state
  int unsigned fq[$];
  logic [15:0] m_color = '0;
  bit m_last_pix = 0, m_fin = 0, model_on = 0;
  int last_we = -100;
  bit e_we = 0, e_ack = 0, e_done = 0;
  bit e_busy = 0, e_err = 0;
  logic [16:0] e_wa = '0;
  logic [15:0] e_wd = '0;
  bit n_we, n_ack, n_done, n_busy, n_err, n_fin;
  bit free, pc, fc, gp, gf, bad;
  logic [16:0] n_wa;
  logic [15:0] n_wd;
  int sx0, sx1, sy0, sy1;

  // WE log for directed checks
  int lw_addr[$];
  int lw_data[$];
  int lw_ack[$];
  int lw_cyc[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (model_on) begin
      bad = (bus.WE !== e_we) || (bus.PIX_ACK !== e_ack)
         || (bus.FILL_DONE !== e_done)
         || (bus.FILL_BUSY !== e_busy)
         || (bus.ERR !== e_err)
         || (bus.WA !== e_wa) || (bus.WD !== e_wd);
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL cycle %0d: got we=%b ack=%b done=%b busy=%b err=%b wa=%0d wd=%h, expected we=%b ack=%b done=%b busy=%b err=%b wa=%0d wd=%h",
          cyc, bus.WE, bus.PIX_ACK, bus.FILL_DONE,
          bus.FILL_BUSY, bus.ERR, bus.WA, bus.WD,
          e_we, e_ack, e_done, e_busy, e_err, e_wa, e_wd);
      end
      if (bus.WE === 1'b1) begin
        lw_addr.push_back(int'(bus.WA));
        lw_data.push_back(int'(bus.WD));
        lw_ack.push_back(int'(bus.PIX_ACK));
        lw_cyc.push_back(cyc);
      end
      if (bus.FILL_DONE === 1'b1) done_cnt++;
    end
    n_we = 0; n_ack = 0; n_done = 0; n_fin = 0;
    n_busy = e_busy; n_err = e_err;
    n_wa = e_wa; n_wd = e_wd;
    if (RESET) begin
      model_on = 1;
      fq.delete();
      m_last_pix = 0;
      last_we = -100;
      n_busy = 0; n_err = 0; n_wa = '0; n_wd = '0;
    end else begin
      if (e_we && m_fin) begin
        n_busy = 0;
        n_done = 1;
      end
      if (e_we) last_we = cyc;
      free = (cyc - last_we > WE_GAP) && !bus.DRV_BUSY;
      pc = bus.PIX_REQ && !e_ack;
      fc = fq.size() > 0;
      gp = free && pc && (!fc || !m_last_pix);
      gf = free && fc && !gp;
      if (gp) begin
        n_ack = 1;
        m_last_pix = 1;
        if (int'(bus.PIX_ADDR) < NPIX) begin
          n_we = 1;
          n_wa = bus.PIX_ADDR;
          n_wd = bus.PIX_DATA;
        end else begin
          n_err = 1;
        end
      end
      if (gf) begin
        n_we = 1;
        n_wa = 17'(fq.pop_front());
        n_wd = m_color;
        m_last_pix = 0;
        n_fin = (fq.size() == 0);
      end
      if (bus.FILL_START && !e_busy) begin
        sx0 = int'(bus.FILL_X0); sx1 = int'(bus.FILL_X1);
        sy0 = int'(bus.FILL_Y0); sy1 = int'(bus.FILL_Y1);
        if (sx0 <= sx1 && sx1 < WIDTH &&
            sy0 <= sy1 && sy1 < HEIGHT) begin
          for (int y = sy0; y <= sy1; y++)
            for (int x = sx0; x <= sx1; x++)
              fq.push_back(y * WIDTH + x);
          m_color = bus.FILL_COLOR;
          n_busy = 1;
        end else begin
          n_err = 1;
        end
      end
    end
    m_fin = n_fin;
    e_we = n_we; e_ack = n_ack; e_done = n_done;
    e_busy = n_busy; e_err = n_err;
    e_wa = n_wa; e_wd = n_wd;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  task automatic clear_log();
    lw_addr.delete(); lw_data.delete();
    lw_ack.delete(); lw_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic do_reset();
    RESET = 1;
    tick(2);
    RESET = 0;
    clear_log();
  endtask

  task automatic pix(input int a, input int d, output bit got);
    got = 0;
    bus.PIX_REQ = 1;
    bus.PIX_ADDR = 17'(a);
    bus.PIX_DATA = 16'(d);
    for (int i = 0; i < 200 && !got; i++) begin
      tick(1);
      if (bus.PIX_ACK) got = 1;
    end
    bus.PIX_REQ = 0;
    if (!got) timeout("pix_ack");
  endtask

  task automatic fill(input int x0, input int y0,
                      input int x1, input int y1,
                      input int c);
    bus.FILL_X0 = 9'(x0); bus.FILL_Y0 = 8'(y0);
    bus.FILL_X1 = 9'(x1); bus.FILL_Y1 = 8'(y1);
    bus.FILL_COLOR = 16'(c);
    bus.FILL_START = 1;
    tick(1);
    bus.FILL_START = 0;
  endtask

  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 3000 && done_cnt == 0; i++) tick(1);
    if (done_cnt == 0) timeout(nm);
    tick(8);
  endtask

  task automatic wait_we(input int n, input string nm);
    int i;
    for (i = 0; i < 500 && lw_addr.size() < n; i++) tick(1);
    if (lw_addr.size() < n) timeout(nm);
  endtask

  function automatic int lg(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  int exp_fill[6] = '{1610, 1611, 1612, 1930, 1931, 1932};
  int exp_cd[3]   = '{16'hAAAA, 16'h5555, 16'h5555};
  int exp_ca[3]   = '{0, 0, 1};
  bit got;
  int min_sp, b0, in_win;

  initial begin
    RESET = 1;
    bus.PIX_REQ = 0; bus.PIX_ADDR = '0; bus.PIX_DATA = '0;
    bus.FILL_START = 0; bus.FILL_X0 = '0; bus.FILL_Y0 = '0;
    bus.FILL_X1 = '0; bus.FILL_Y1 = '0; bus.FILL_COLOR = '0;
    bus.DRV_BUSY = 0;
    tick(3);
    RESET = 0;
    clear_log();
    check("reset_flags",
      {bus.WE, bus.PIX_ACK, bus.FILL_BUSY, bus.FILL_DONE, bus.ERR},
      0);

    // single pixel
    pix(321, 16'hF800, got);
    tick(8);
    check("pix_we_count", lw_addr.size(), 1);
    check("pix_wa", lg(lw_addr, 0), 321);
    check("pix_wd", lg(lw_data, 0), 16'hF800);
    check("pix_ack_with_we", lg(lw_ack, 0), 1);

    do_reset();
    check("reset_wa", bus.WA, 0);
    check("reset_wd", bus.WD, 0);

    // rectangle fill
    fill(10, 5, 12, 6, 16'h07E0);
    wait_done("fill_done");
    check("fill_we_count", lw_addr.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("fill_wa%0d", i), lg(lw_addr, i), exp_fill[i]);
    check("fill_wd", lg(lw_data, 5), 16'h07E0);
    check("fill_done_count", done_cnt, 1);
    min_sp = 1000;
    for (int i = 1; i < lw_cyc.size(); i++)
      if (lw_cyc[i] - lw_cyc[i-1] < min_sp)
        min_sp = lw_cyc[i] - lw_cyc[i-1];
    check("fill_spacing", min_sp >= WE_GAP + 1, 1);

    // contention: pixel wins the first tie after reset
    do_reset();
    bus.FILL_X0 = 9'd0; bus.FILL_Y0 = 8'd0;
    bus.FILL_X1 = 9'd1; bus.FILL_Y1 = 8'd0;
    bus.FILL_COLOR = 16'h5555;
    bus.FILL_START = 1;
    bus.PIX_REQ = 1; bus.PIX_ADDR = '0; bus.PIX_DATA = 16'hAAAA;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick(1);
      bus.FILL_START = 0;
      if (bus.PIX_ACK) got = 1;
    end
    bus.PIX_REQ = 0;
    if (!got) timeout("cont_ack");
    wait_done("cont_done");
    check("cont_we_count", lw_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cont_wd%0d", i), lg(lw_data, i), exp_cd[i]);
      check($sformatf("cont_wa%0d", i), lg(lw_addr, i), exp_ca[i]);
    end

    // backpressure mid-fill
    do_reset();
    fill(0, 0, 9, 0, 16'h1234);
    wait_we(3, "bp_first3");
    tick(1);
    bus.DRV_BUSY = 1;
    b0 = cyc;
    tick(50);
    bus.DRV_BUSY = 0;
    wait_done("bp_done");
    in_win = 0;
    foreach (lw_cyc[i])
      if (lw_cyc[i] > b0 && lw_cyc[i] <= b0 + 50) in_win++;
    check("bp_no_we_while_busy", in_win, 0);
    check("bp_we_count", lw_addr.size(), 10);
    for (int i = 0; i < 10; i++)
      check($sformatf("bp_wa%0d", i), lg(lw_addr, i), i);

    // invalid fill
    do_reset();
    fill(0, 0, 320, 0, 16'hFFFF);
    tick(20);
    check("badfill_err", bus.ERR, 1);
    check("badfill_busy", bus.FILL_BUSY, 0);
    check("badfill_we", lw_addr.size(), 0);
    check("badfill_done", done_cnt, 0);

    // out-of-range pixel
    do_reset();
    pix(NPIX, 16'h1111, got);
    tick(10);
    check("badpix_ack", got, 1);
    check("badpix_err", bus.ERR, 1);
    check("badpix_we", lw_addr.size(), 0);

    // reset mid-fill
    do_reset();
    fill(0, 0, 319, 0, 16'hFFFF);
    wait_we(3, "rst_first3");
    RESET = 1;
    tick(1);
    RESET = 0;
    clear_log();
    tick(60);
    check("rst_we", lw_addr.size(), 0);
    check("rst_done", done_cnt, 0);
    check("rst_busy", bus.FILL_BUSY, 0);
    check("rst_err", bus.ERR, 0);

    // random traffic against the model
    do_reset();
    for (int n = 0; n < 6000; n++) begin
      RESET = ($urandom_range(0, 1499) == 0);
      if (bus.PIX_REQ && bus.PIX_ACK) begin
        bus.PIX_REQ = 0;
      end else if (!bus.PIX_REQ && $urandom_range(0, 5) == 0) begin
        bus.PIX_REQ = 1;
        bus.PIX_ADDR = ($urandom_range(0, 15) == 0)
          ? 17'(NPIX + $urandom_range(0, 99))
          : 17'($urandom_range(0, NPIX - 1));
        bus.PIX_DATA = 16'($urandom);
      end
      if ($urandom_range(0, 30) == 0) begin
        sx0 = $urandom_range(0, WIDTH - 1);
        sx1 = sx0 + $urandom_range(0, 3);
        sy0 = $urandom_range(0, HEIGHT - 1);
        sy1 = sy0 + $urandom_range(0, 2);
        if ($urandom_range(0, 9) == 0 && sx0 > 0) sx1 = sx0 - 1;
        bus.FILL_X0 = 9'(sx0); bus.FILL_X1 = 9'(sx1);
        bus.FILL_Y0 = 8'(sy0); bus.FILL_Y1 = 8'(sy1);
        bus.FILL_COLOR = 16'($urandom);
        bus.FILL_START = 1;
      end else begin
        bus.FILL_START = 0;
      end
      if ($urandom_range(0, 9) == 0) bus.DRV_BUSY = !bus.DRV_BUSY;
      tick(1);
    end
    RESET = 0;
    bus.PIX_REQ = 0;
    bus.FILL_START = 0;
    bus.DRV_BUSY = 0;
    tick(200);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
